// File: rtl/river_pkg.sv
// Shared encodings for the river-crossing controller.
// Passenger codes, FSM states and position bit indices.
package river_pkg;

  localparam logic [1:0] P_NONE    = 2'b00;
  localparam logic [1:0] P_CABBAGE = 2'b01;
  localparam logic [1:0] P_GOAT    = 2'b10;
  localparam logic [1:0] P_WOLF    = 2'b11;

  localparam int F_BIT = 3;
  localparam int C_BIT = 2;
  localparam int G_BIT = 1;
  localparam int W_BIT = 0;

  localparam logic [3:0] F_MASK = 4'b1000;

  typedef enum logic [1:0] {
    PLAY,
    CROSS,
    LOST,
    WON
  } state_t;

  // One-hot pos mask of the character riding with the farmer.
  function automatic logic [3:0] pass_mask(
    input logic [1:0] p
  );
    logic [3:0] m;
    m = 4'b0000;
    unique case (p)
      P_CABBAGE: m[C_BIT] = 1'b1;
      P_GOAT:    m[G_BIT] = 1'b1;
      P_WOLF:    m[W_BIT] = 1'b1;
      default:   m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/crossing_alarm.sv
// Combinational unsafe-position checker.
// Goat left with cabbage or wolf without the farmer.
module crossing_alarm
  import river_pkg::*;
(
  input  logic [3:0] pos,
  output logic       unsafe
);

  logic goat_alone;
  logic goat_pair;

  assign goat_alone = pos[F_BIT] != pos[G_BIT];
  assign goat_pair  = (pos[G_BIT] == pos[C_BIT]) ||
                      (pos[G_BIT] == pos[W_BIT]);
  assign unsafe     = goat_alone && goat_pair;

endmodule

// File: rtl/river_crossing_ctrl.sv
// River-crossing game sequencer: FSM, transit timer,
// position register and saturating move counter.
module river_crossing_ctrl
  import river_pkg::*;
#(
  parameter int CROSS_CYCLES = 4,
  parameter int MOVE_W       = 5
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              move_req,
  input  logic [1:0]        passenger,
  input  logic              restart,
  output logic [3:0]        pos,
  output logic              busy,
  output logic              alarm,
  output logic              won,
  output logic              illegal,
  output logic [MOVE_W-1:0] moves
);

  localparam int CNT_W =
    (CROSS_CYCLES > 1) ? $clog2(CROSS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(CROSS_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       pass_q;
  logic [3:0]       npos;
  logic             unsafe;
  logic             legal;
  logic             with_farmer;

  assign with_farmer =
    (|(pos & pass_mask(passenger))) == pos[F_BIT];
  assign legal = (passenger == P_NONE) || with_farmer;
  assign npos  = pos ^ (F_MASK | pass_mask(pass_q));

  crossing_alarm u_alarm (
    .pos    (npos),
    .unsafe (unsafe)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= PLAY;
      cnt     <= '0;
      pass_q  <= P_NONE;
      pos     <= 4'b0000;
      busy    <= 1'b0;
      alarm   <= 1'b0;
      won     <= 1'b0;
      illegal <= 1'b0;
      moves   <= '0;
    end else if (restart) begin
      state   <= PLAY;
      cnt     <= '0;
      pass_q  <= P_NONE;
      pos     <= 4'b0000;
      busy    <= 1'b0;
      alarm   <= 1'b0;
      won     <= 1'b0;
      illegal <= 1'b0;
      moves   <= '0;
    end else begin
      illegal <= 1'b0;
      unique case (state)
        PLAY: begin
          if (move_req) begin
            if (legal) begin
              state  <= CROSS;
              cnt    <= CNT_LOAD;
              pass_q <= passenger;
              busy   <= 1'b1;
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        CROSS: begin
          if (cnt == '0) begin
            pos  <= npos;
            busy <= 1'b0;
            if (moves != '1)
              moves <= moves + MOVE_W'(1);
            if (npos == 4'b1111) begin
              state <= WON;
              won   <= 1'b1;
            end else if (unsafe) begin
              state <= LOST;
              alarm <= 1'b1;
            end else begin
              state <= PLAY;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        LOST: state <= LOST;
        WON:  state <= WON;
      endcase
    end
  end

endmodule

// File: tb/tb_river_crossing_ctrl.sv
// Scenario bench for river_crossing_ctrl with an
// expected-arrival scoreboard.
module tb_river_crossing_ctrl;

  localparam int CC = 4;
  localparam int MW = 5;
  localparam int MAXMV = (1 << MW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          move_req = 1'b0;
  logic [1:0]    passenger = 2'b00;
  logic          restart = 1'b0;
  logic [3:0]    pos;
  logic          busy;
  logic          alarm;
  logic          won;
  logic          illegal;
  logic [MW-1:0] moves;

  typedef struct packed {
    logic [3:0]    pos;
    logic [MW-1:0] moves;
    logic          alarm;
    logic          won;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] mpos = 4'b0000;
  int         mmoves = 0;

  river_crossing_ctrl #(
    .CROSS_CYCLES (CC),
    .MOVE_W       (MW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .move_req  (move_req),
    .passenger (passenger),
    .restart   (restart),
    .pos       (pos),
    .busy      (busy),
    .alarm     (alarm),
    .won       (won),
    .illegal   (illegal),
    .moves     (moves)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] bmask(input logic [1:0] p);
    case (p)
      2'b01:   return 4'b0100;
      2'b10:   return 4'b0010;
      2'b11:   return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic restart_game();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    mpos = 4'b0000;
    mmoves = 0;
  endtask

  task automatic do_cross(input logic [1:0] p);
    exp_t       e;
    exp_t       got;
    int         n;
    logic [3:0] np;
    logic       ok;
    ok = (p == 2'b00) ||
         (((mpos & bmask(p)) != 4'b0000) == mpos[3]);
    if (ok) begin
      np = mpos ^ (4'b1000 | bmask(p));
      if (mmoves < MAXMV) mmoves++;
      e.pos   = np;
      e.moves = MW'(mmoves);
      e.won   = (np == 4'b1111);
      e.alarm = !e.won && (np[3] != np[1]) &&
                (np[1] == np[2] || np[1] == np[0]);
      sb.push_back(e);
      mpos = np;
    end
    move_req  = 1'b1;
    passenger = p;
    tick();
    move_req  = 1'b0;
    passenger = 2'($urandom_range(0, 3));
    if (ok) begin
      n = 0;
      while (busy && n < 40) begin
        n++;
        tick();
      end
      checks++;
      if (n !== CC) begin
        errors++;
        $display("FAIL busy_len got %0d want %0d", n, CC);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty got 0 want 1");
      end else begin
        e = sb.pop_front();
        got = '{pos: pos, moves: moves,
                alarm: alarm, won: won};
        if (got !== e) begin
          errors++;
          $display("FAIL arrive got %h want %h", got, e);
        end
      end
    end else begin
      checks++;
      if (illegal !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL illegal_pulse got %b%b want 10",
                 illegal, busy);
      end
      tick();
      checks++;
      if (illegal !== 1'b0 || busy !== 1'b0 ||
          pos !== mpos || moves !== MW'(mmoves)) begin
        errors++;
        $display("FAIL illegal_hold got %b %b %b %0d want 0 0 %b %0d",
                 illegal, busy, pos, moves, mpos, mmoves);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({pos, busy, alarm, won, illegal} !== 8'h00 ||
        moves !== '0) begin
      errors++;
      $display("FAIL reset got %b %b%b%b%b %0d want 0000 0000 0",
               pos, busy, alarm, won, illegal, moves);
    end
  endtask

  task automatic test_goat();
    do_cross(2'b10);
    checks++;
    if (pos !== 4'b1010) begin
      errors++;
      $display("FAIL goat_pos got %b want 1010", pos);
    end
  endtask

  task automatic test_loss();
    restart_game();
    do_cross(2'b00);
    checks++;
    if (pos !== 4'b1000 || alarm !== 1'b1) begin
      errors++;
      $display("FAIL loss got %b %b want 1000 1", pos, alarm);
    end
    move_req = 1'b1;
    passenger = 2'b00;
    tick();
    move_req = 1'b0;
    checks++;
    if (illegal !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL lost_ignore got %b%b want 00", illegal, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || pos !== 4'b1000) begin
      errors++;
      $display("FAIL lost_hold got %b %b want 0 1000", busy, pos);
    end
    restart_game();
    checks++;
    if (pos !== 4'b0000 || alarm !== 1'b0 || moves !== '0) begin
      errors++;
      $display("FAIL loss_restart got %b %b %0d want 0000 0 0",
               pos, alarm, moves);
    end
  endtask

  task automatic test_illegal();
    restart_game();
    do_cross(2'b10);
    do_cross(2'b01);
    checks++;
    if (pos !== 4'b1010 || moves !== MW'(1)) begin
      errors++;
      $display("FAIL illegal_state got %b %0d want 1010 1",
               pos, moves);
    end
  endtask

  task automatic test_win();
    logic [1:0] seq[7];
    logic [3:0] want[7];
    seq  = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10};
    want = '{4'b1010, 4'b0010, 4'b1110, 4'b0100,
             4'b1101, 4'b0101, 4'b1111};
    restart_game();
    for (int i = 0; i < 7; i++) begin
      do_cross(seq[i]);
      checks++;
      if (pos !== want[i]) begin
        errors++;
        $display("FAIL win_step%0d got %b want %b",
                 i, pos, want[i]);
      end
    end
    checks++;
    if (won !== 1'b1 || alarm !== 1'b0 || moves !== MW'(7)) begin
      errors++;
      $display("FAIL win_end got %b %b %0d want 1 0 7",
               won, alarm, moves);
    end
    move_req = 1'b1;
    tick();
    move_req = 1'b0;
    checks++;
    if (busy !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL won_ignore got %b%b want 00", busy, illegal);
    end
  endtask

  task automatic test_abort();
    restart_game();
    move_req = 1'b1;
    passenger = 2'b10;
    tick();
    move_req = 1'b0;
    tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    checks++;
    if (pos !== 4'b0000 || busy !== 1'b0 || moves !== '0) begin
      errors++;
      $display("FAIL abort got %b %b %0d want 0000 0 0",
               pos, busy, moves);
    end
    restart = 1'b1;
    move_req = 1'b1;
    passenger = 2'b10;
    tick();
    restart = 1'b0;
    move_req = 1'b0;
    checks++;
    if (busy !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL restart_prio got %b%b want 00", busy, illegal);
    end
    for (int i = 0; i < CC + 1; i++) tick();
    checks++;
    if (pos !== 4'b0000 || moves !== '0) begin
      errors++;
      $display("FAIL restart_prio_pos got %b %0d want 0000 0",
               pos, moves);
    end
    mpos = 4'b0000;
    mmoves = 0;
  endtask

  task automatic test_reset_mid();
    restart_game();
    move_req = 1'b1;
    passenger = 2'b10;
    tick();
    move_req = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || pos !== 4'b0000 || moves !== '0) begin
      errors++;
      $display("FAIL async_reset got %b %b %0d want 0 0000 0",
               busy, pos, moves);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < CC + 2; i++) tick();
    checks++;
    if (pos !== 4'b0000 || moves !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL no_pending got %b %0d %b want 0000 0 0",
               pos, moves, busy);
    end
  endtask

  task automatic test_saturate();
    restart_game();
    for (int i = 0; i < MAXMV + 3; i++) do_cross(2'b10);
    checks++;
    if (moves !== MW'(MAXMV)) begin
      errors++;
      $display("FAIL saturate got %0d want %0d", moves, MAXMV);
    end
  endtask

  initial begin
    test_reset();
    test_goat();
    test_loss();
    test_illegal();
    test_win();
    test_abort();
    test_reset_mid();
    test_saturate();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
